// File: rtl/muldiv_sequencer.sv
// Sequences the shared MULT and DIV units for the Control FSM: start pulse,
// wait for the unit's stop flag, then a single HI/LO write, exception or timeout.
module muldiv_sequencer #(
    parameter int TIMEOUT = 40,
    parameter int CW      = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_mult,
    input  logic          req_div,
    input  logic          abort,
    input  logic          mult_stop,
    input  logic          div_stop,
    input  logic          div_zero,
    output logic          ctrl_mult,
    output logic          ctrl_div,
    output logic          ctrl_hilo,
    output logic          hi_lo_write,
    output logic          busy,
    output logic          done,
    output logic          div_zero_exc,
    output logic          timeout_err,
    output logic [CW-1:0] last_cycles
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        EXC   = 3'd5,
        TERR  = 3'd6
    } state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          op_q, op_d;
    logic [CW-1:0] last_cycles_q, last_cycles_d;
    logic          ctrl_mult_q, ctrl_mult_d;
    logic          ctrl_div_q, ctrl_div_d;
    logic          ctrl_hilo_q, ctrl_hilo_d;
    logic          hi_lo_write_q, hi_lo_write_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          div_zero_exc_q, div_zero_exc_d;
    logic          timeout_err_q, timeout_err_d;
    logic          sel_stop;

    // Only the unit that was started may end the wait; the other flag is ignored.
    assign sel_stop = op_q ? mult_stop : div_stop;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        op_d          = op_q;
        last_cycles_d = last_cycles_q;

        case (state_q)
            IDLE: begin
                if (req_mult) begin
                    state_d = START;
                    op_d    = 1'b1;
                end else if (req_div) begin
                    state_d = START;
                    op_d    = 1'b0;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
                if (abort) begin
                    state_d = IDLE;
                end else if (sel_stop) begin
                    if (!op_q && div_zero) begin
                        state_d = EXC;
                    end else begin
                        state_d       = WRITE;
                        last_cycles_d = cnt_q + CW'(1);
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = TERR;
                end
            end
            WRITE:   state_d = DONE;
            DONE:    state_d = IDLE;
            EXC:     state_d = IDLE;
            TERR:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they appear registered.
        ctrl_mult_d    = (state_d == START) && op_d;
        ctrl_div_d     = (state_d == START) && !op_d;
        ctrl_hilo_d    = (state_d == START) ? op_d : ctrl_hilo_q;
        hi_lo_write_d  = (state_d == WRITE);
        busy_d         = (state_d == START) || (state_d == WAIT) || (state_d == WRITE);
        done_d         = (state_d == DONE);
        div_zero_exc_d = (state_d == EXC);
        timeout_err_d  = (state_d == TERR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            op_q           <= 1'b0;
            last_cycles_q  <= '0;
            ctrl_mult_q    <= 1'b0;
            ctrl_div_q     <= 1'b0;
            ctrl_hilo_q    <= 1'b0;
            hi_lo_write_q  <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            div_zero_exc_q <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            op_q           <= op_d;
            last_cycles_q  <= last_cycles_d;
            ctrl_mult_q    <= ctrl_mult_d;
            ctrl_div_q     <= ctrl_div_d;
            ctrl_hilo_q    <= ctrl_hilo_d;
            hi_lo_write_q  <= hi_lo_write_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            div_zero_exc_q <= div_zero_exc_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    assign ctrl_mult    = ctrl_mult_q;
    assign ctrl_div     = ctrl_div_q;
    assign ctrl_hilo    = ctrl_hilo_q;
    assign hi_lo_write  = hi_lo_write_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign div_zero_exc = div_zero_exc_q;
    assign timeout_err  = timeout_err_q;
    assign last_cycles  = last_cycles_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: a vector table for short sequences plus
// hand-written long-wait, timeout and asynchronous-reset scenarios.
module tb_muldiv_sequencer;

    localparam int TIMEOUT = 40;
    localparam int CW      = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_mult, req_div, abort, mult_stop, div_stop, div_zero;
    logic          ctrl_mult, ctrl_div, ctrl_hilo, hi_lo_write;
    logic          busy, done, div_zero_exc, timeout_err;
    logic [CW-1:0] last_cycles;

    int checks   = 0;
    int failures = 0;

    muldiv_sequencer #(.TIMEOUT(TIMEOUT), .CW(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_mult    (req_mult),
        .req_div     (req_div),
        .abort       (abort),
        .mult_stop   (mult_stop),
        .div_stop    (div_stop),
        .div_zero    (div_zero),
        .ctrl_mult   (ctrl_mult),
        .ctrl_div    (ctrl_div),
        .ctrl_hilo   (ctrl_hilo),
        .hi_lo_write (hi_lo_write),
        .busy        (busy),
        .done        (done),
        .div_zero_exc(div_zero_exc),
        .timeout_err (timeout_err),
        .last_cycles (last_cycles)
    );

    always #5 clk = ~clk;

    // Stimulus bits {req_mult, req_div, abort, mult_stop, div_stop, div_zero};
    // output bits {busy, ctrl_mult, ctrl_div, ctrl_hilo, hi_lo_write, done, div_zero_exc, timeout_err}.
    typedef struct {
        logic [5:0]    stim;
        logic [7:0]    expOut;
        logic [CW-1:0] expLast;
    } vec_t;

    vec_t vecs[23];

    function automatic logic [7:0] outVec();
        return {busy, ctrl_mult, ctrl_div, ctrl_hilo, hi_lo_write, done, div_zero_exc, timeout_err};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Drive inputs, then let one active edge pass and settle before sampling.
    task automatic applyStimulus(input logic [5:0] s);
        {req_mult, req_div, abort, mult_stop, div_stop, div_zero} = s;
        @(posedge clk);
        #1;
    endtask

    // One full mult/div op whose stop flag arrives in WAIT cycle n.
    task automatic runOp(input logic isMult, input int n, input string tag);
        int selPulses;
        int otherPulses;
        int writes;
        logic [5:0] stopStim;
        selPulses   = 0;
        otherPulses = 0;
        writes      = 0;
        stopStim    = isMult ? 6'b000100 : 6'b000010;
        applyStimulus(isMult ? 6'b100000 : 6'b010000);
        selPulses   += isMult ? int'(ctrl_mult) : int'(ctrl_div);
        otherPulses += isMult ? int'(ctrl_div) : int'(ctrl_mult);
        checkOutput({tag, "_start_busy"}, busy, 1);
        for (int i = 0; i < n; i++) begin
            applyStimulus(6'b000000);
            selPulses   += isMult ? int'(ctrl_mult) : int'(ctrl_div);
            otherPulses += isMult ? int'(ctrl_div) : int'(ctrl_mult);
            writes      += int'(hi_lo_write);
            checkOutput({tag, "_wait_hilo"}, ctrl_hilo, isMult);
        end
        applyStimulus(stopStim);
        checkOutput({tag, "_write"}, hi_lo_write, 1);
        checkOutput({tag, "_write_hilo"}, ctrl_hilo, isMult);
        checkOutput({tag, "_last_cycles"}, last_cycles, n);
        applyStimulus(6'b000000);
        checkOutput({tag, "_done_vec"}, outVec(), {4'b0000, 1'b0, 1'b1, 2'b00} | {3'b000, isMult, 4'b0000});
        applyStimulus(6'b000000);
        checkOutput({tag, "_idle_busy"}, busy, 0);
        checkOutput({tag, "_start_pulses"}, selPulses, 1);
        checkOutput({tag, "_other_pulses"}, otherPulses, 0);
        checkOutput({tag, "_early_writes"}, writes, 0);
    endtask

    initial begin
        int cycles;

        vecs[0]  = '{6'b100000, 8'b11010000, 6'd0};
        vecs[1]  = '{6'b000000, 8'b10010000, 6'd0};
        vecs[2]  = '{6'b000100, 8'b10011000, 6'd1};
        vecs[3]  = '{6'b000000, 8'b00010100, 6'd1};
        vecs[4]  = '{6'b000000, 8'b00010000, 6'd1};
        vecs[5]  = '{6'b110000, 8'b11010000, 6'd1};
        vecs[6]  = '{6'b010000, 8'b10010000, 6'd1};
        vecs[7]  = '{6'b010010, 8'b10010000, 6'd1};
        vecs[8]  = '{6'b001000, 8'b00010000, 6'd1};
        vecs[9]  = '{6'b010000, 8'b10100000, 6'd1};
        vecs[10] = '{6'b000000, 8'b10000000, 6'd1};
        vecs[11] = '{6'b000100, 8'b10000000, 6'd1};
        vecs[12] = '{6'b000011, 8'b00000010, 6'd1};
        vecs[13] = '{6'b000000, 8'b00000000, 6'd1};
        vecs[14] = '{6'b010000, 8'b10100000, 6'd1};
        vecs[15] = '{6'b000000, 8'b10000000, 6'd1};
        vecs[16] = '{6'b000000, 8'b10000000, 6'd1};
        vecs[17] = '{6'b000010, 8'b10001000, 6'd2};
        vecs[18] = '{6'b101000, 8'b00000100, 6'd2};
        vecs[19] = '{6'b100000, 8'b00000000, 6'd2};
        vecs[20] = '{6'b100000, 8'b11010000, 6'd2};
        vecs[21] = '{6'b001000, 8'b10010000, 6'd2};
        vecs[22] = '{6'b001000, 8'b00010000, 6'd2};

        reset = 1'b1;
        {req_mult, req_div, abort, mult_stop, div_stop, div_zero} = 6'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_outputs", outVec(), 0);
        checkOutput("reset_last_cycles", last_cycles, 0);
        reset = 1'b0;

        for (int i = 0; i < 23; i++) begin
            applyStimulus(vecs[i].stim);
            checkOutput($sformatf("vec%0d_outputs", i), outVec(), vecs[i].expOut);
            checkOutput($sformatf("vec%0d_last_cycles", i), last_cycles, vecs[i].expLast);
        end

        runOp(1'b1, 33, "mult33");
        runOp(1'b0, 33, "div33");

        applyStimulus(6'b100000);
        cycles = 0;
        while (!timeout_err && cycles < 60) begin
            applyStimulus(6'b000000);
            cycles++;
        end
        checkOutput("timeout_cycles", cycles, 41);
        checkOutput("timeout_busy", busy, 0);
        checkOutput("timeout_no_write", hi_lo_write, 0);
        applyStimulus(6'b000000);
        checkOutput("timeout_idle", outVec(), 8'b00010000);
        checkOutput("timeout_last_cycles", last_cycles, 33);

        applyStimulus(6'b100000);
        repeat (3) applyStimulus(6'b000000);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_outputs", outVec(), 0);
        checkOutput("async_reset_last_cycles", last_cycles, 0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(6'b000100);
            checkOutput($sformatf("post_reset_stop%0d", i), outVec(), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
